// File: rtl/dc_write_port_pkg.sv
// dc_write_port_pkg: FSM state codes, store type codes and byte-enable formatting shared by the write port
package dc_write_port_pkg;
  localparam logic [1:0] DCWP_IDLE = 2'd0;
  localparam logic [1:0] DCWP_ST_WAIT = 2'd1;
  localparam logic [1:0] DCWP_LD_WAIT = 2'd2;
  localparam logic SB_TYPE_WORD = 1'b0;
  localparam logic SB_TYPE_BYTE = 1'b1;
  function automatic logic [3:0] fmt_be(input logic t, input logic [1:0] a);
    return t == SB_TYPE_BYTE ? 4'b0001 << a : 4'hF;
  endfunction
endpackage

// File: rtl/dc_write_port_if.sv
// dc_write_port_if: one-outstanding req/ack D-cache bus (req/we/addr/wdata/be out, ack/rdata back)
interface dc_write_port_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0] be;
  logic ack;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, be, input ack, rdata);
  modport slave(input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/dc_wq_fifo.sv
// dc_wq_fifo: store write queue; push/pop, full/empty, head entry and parallel word-address conflict compare
module dc_wq_fifo #(
  parameter int DEPTH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_wdata,
  input  logic              push_type,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_wdata,
  output logic              head_type,
  input  logic [ADDR_W-3:0] cmp_wa,
  output logic              conflict
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DEPTH-1:0] type_q, vld;
  logic wr;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  // a full queue still accepts a push when the head leaves on the same edge
  assign wr = push && (!full || pop);
  assign head_addr = addr_q[rp[AW-1:0]];
  assign head_wdata = wdata_q[rp[AW-1:0]];
  assign head_type = type_q[rp[AW-1:0]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      vld <= '0;
    end else begin
      if (pop) begin
        rp <= rp + 1'b1;
        vld[rp[AW-1:0]] <= 1'b0;
      end
      if (wr) begin
        wp <= wp + 1'b1;
        vld[wp[AW-1:0]] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      addr_q[wp[AW-1:0]] <= push_addr;
      wdata_q[wp[AW-1:0]] <= push_wdata;
      type_q[wp[AW-1:0]] <= push_type;
    end
  end
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      conflict = conflict | (vld[i] && addr_q[i][ADDR_W-1:2] == cmp_wa);
  end
endmodule

// File: rtl/dc_write_port.sv
// dc_write_port: queues store drains, arbitrates stores vs. load misses onto the D-cache bus, returns hit_dc, load data and stall
// ports: clk/reset; sb_* store-buffer drain/load miss in; hit_dc completion pulse; dc cache bus (master);
//        ld_data/ld_valid/stall to MEM stage; err_ovf sticky queue-overflow flag
module dc_write_port
  import dc_write_port_pkg::*;
#(
  parameter int WQ_DEPTH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sb_store,
  input  logic              sb_load,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [DATA_W-1:0] sb_wdata,
  input  logic              sb_type,
  output logic              hit_dc,
  dc_write_port_if.master   dc,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              stall,
  output logic              err_ovf
);
  logic [1:0] state;
  logic ld_pend;
  logic [ADDR_W-3:0] ld_wa;
  logic full, empty, conflict, head_type;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic idle, pop, fin_ld, go_ld, go_st;
  dc_wq_fifo #(.DEPTH(WQ_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wq (
    .clk(clk),
    .reset(reset),
    .push(sb_store),
    .pop(pop),
    .push_addr(sb_addr),
    .push_wdata(sb_wdata),
    .push_type(sb_type),
    .full(full),
    .empty(empty),
    .head_addr(head_addr),
    .head_wdata(head_wdata),
    .head_type(head_type),
    .cmp_wa(ld_wa),
    .conflict(conflict)
  );
  assign idle = state == DCWP_IDLE;
  assign pop = state == DCWP_ST_WAIT && dc.ack;
  assign fin_ld = state == DCWP_LD_WAIT && dc.ack;
  // a load may bypass queued stores only when none of them touches its word and the queue is not full
  assign go_ld = idle && ld_pend && !conflict && !full;
  assign go_st = idle && !empty && !go_ld;
  assign stall = ld_pend | (state == DCWP_LD_WAIT);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DCWP_IDLE;
      ld_pend <= 1'b0;
      ld_wa <= '0;
      dc.req <= 1'b0;
      dc.we <= 1'b0;
      dc.addr <= '0;
      dc.wdata <= '0;
      dc.be <= '0;
      hit_dc <= 1'b0;
      ld_data <= '0;
      ld_valid <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      hit_dc <= pop | fin_ld;
      ld_valid <= fin_ld;
      if (fin_ld) ld_data <= dc.rdata;
      if (sb_store && full && !pop) err_ovf <= 1'b1;
      if (fin_ld) ld_pend <= 1'b0;
      else if (sb_load && !ld_pend) begin
        ld_pend <= 1'b1;
        ld_wa <= sb_wdata[ADDR_W-1:2];
      end
      if (pop || fin_ld) begin
        state <= DCWP_IDLE;
        dc.req <= 1'b0;
      end else if (go_st) begin
        state <= DCWP_ST_WAIT;
        dc.req <= 1'b1;
        dc.we <= 1'b1;
        dc.addr <= head_type == SB_TYPE_BYTE ? head_addr : {head_addr[ADDR_W-1:2], 2'b00};
        dc.wdata <= head_type == SB_TYPE_BYTE ? {(DATA_W/8){head_wdata[7:0]}} : head_wdata;
        dc.be <= fmt_be(head_type, head_addr[1:0]);
      end else if (go_ld) begin
        state <= DCWP_LD_WAIT;
        dc.req <= 1'b1;
        dc.we <= 1'b0;
        dc.addr <= {ld_wa, 2'b00};
        dc.be <= 4'hF;
      end
    end
  end
endmodule

// File: tb/tb_dc_write_port.sv
// tb_dc_write_port: directed self-checking bench for dc_write_port
module tb_dc_write_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sb_store = 1'b0;
  logic sb_load = 1'b0;
  logic [31:0] sb_addr = '0;
  logic [31:0] sb_wdata = '0;
  logic sb_type = 1'b0;
  logic hit_dc, ld_valid, stall, err_ovf;
  logic [31:0] ld_data;
  int n_chk = 0;
  int n_fail = 0;
  dc_write_port_if #(.ADDR_W(32), .DATA_W(32)) dc_if ();
  dc_write_port #(.WQ_DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .sb_store(sb_store),
    .sb_load(sb_load),
    .sb_addr(sb_addr),
    .sb_wdata(sb_wdata),
    .sb_type(sb_type),
    .hit_dc(hit_dc),
    .dc(dc_if),
    .ld_data(ld_data),
    .ld_valid(ld_valid),
    .stall(stall),
    .err_ovf(err_ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic t);
    sb_store = 1'b1;
    sb_addr = a;
    sb_wdata = d;
    sb_type = t;
    tick();
    sb_store = 1'b0;
  endtask
  task automatic load(input logic [31:0] a);
    sb_load = 1'b1;
    sb_wdata = a;
    tick();
    sb_load = 1'b0;
  endtask
  task automatic ack(input logic [31:0] rd);
    dc_if.ack = 1'b1;
    dc_if.rdata = rd;
    tick();
    dc_if.ack = 1'b0;
  endtask
  initial begin
    dc_if.ack = 1'b0;
    dc_if.rdata = '0;
    repeat (2) tick();
    check("rst_req", dc_if.req, 0);
    check("rst_hit", hit_dc, 0);
    check("rst_ldv", ld_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_err", err_ovf, 0);
    check("rst_ldd", ld_data, 0);
    reset = 1'b0;
    tick();
    store(32'h100, 32'hDEADBEEF, 1'b0);
    tick();
    check("w_req", dc_if.req, 1);
    check("w_we", dc_if.we, 1);
    check("w_addr", dc_if.addr, 32'h100);
    check("w_be", dc_if.be, 4'hF);
    check("w_wdata", dc_if.wdata, 32'hDEADBEEF);
    tick();
    tick();
    check("w_hold_req", dc_if.req, 1);
    check("w_hold_addr", dc_if.addr, 32'h100);
    ack(0);
    check("w_hit", hit_dc, 1);
    check("w_req_drop", dc_if.req, 0);
    tick();
    check("w_hit_pulse", hit_dc, 0);
    tick();
    check("w_drained", dc_if.req, 0);
    store(32'h203, 32'h000000AB, 1'b1);
    tick();
    check("b_we", dc_if.we, 1);
    check("b_addr", dc_if.addr, 32'h203);
    check("b_be", dc_if.be, 4'h8);
    check("b_wdata", dc_if.wdata, 32'hABABABAB);
    ack(0);
    check("b_hit", hit_dc, 1);
    store(32'h107, 32'hCAFEF00D, 1'b0);
    tick();
    check("wa_addr", dc_if.addr, 32'h104);
    check("wa_be", dc_if.be, 4'hF);
    check("wa_wdata", dc_if.wdata, 32'hCAFEF00D);
    ack(0);
    store(32'h40, 32'h11, 1'b0);
    load(32'h40);
    check("s3_st_first", dc_if.we, 1);
    check("s3_st_addr", dc_if.addr, 32'h40);
    check("s3_stall", stall, 1);
    ack(0);
    check("s3_st_hit", hit_dc, 1);
    check("s3_stall2", stall, 1);
    check("s3_ldv_early", ld_valid, 0);
    tick();
    check("s3_ld_req", dc_if.req, 1);
    check("s3_ld_we", dc_if.we, 0);
    check("s3_ld_addr", dc_if.addr, 32'h40);
    check("s3_ld_be", dc_if.be, 4'hF);
    check("s3_stall3", stall, 1);
    ack(32'h11);
    check("s3_ldv", ld_valid, 1);
    check("s3_ldd", ld_data, 32'h11);
    check("s3_ld_hit", hit_dc, 1);
    check("s3_stall_low", stall, 0);
    check("s3_req_drop", dc_if.req, 0);
    tick();
    check("s3_ldv_pulse", ld_valid, 0);
    store(32'h80, 32'h1, 1'b0);
    store(32'h44, 32'h2, 1'b0);
    load(32'h44);
    check("cf_a_addr", dc_if.addr, 32'h80);
    ack(0);
    tick();
    check("cf_st_we", dc_if.we, 1);
    check("cf_st_addr", dc_if.addr, 32'h44);
    ack(0);
    tick();
    check("cf_ld_we", dc_if.we, 0);
    check("cf_ld_addr", dc_if.addr, 32'h44);
    ack(32'h55);
    check("cf_ldv", ld_valid, 1);
    check("cf_ldd", ld_data, 32'h55);
    store(32'h80, 32'h3, 1'b0);
    store(32'h60, 32'h4, 1'b0);
    load(32'h44);
    ack(0);
    tick();
    check("nc_ld_we", dc_if.we, 0);
    check("nc_ld_addr", dc_if.addr, 32'h44);
    ack(32'h77);
    check("nc_ldd", ld_data, 32'h77);
    tick();
    check("nc_st_we", dc_if.we, 1);
    check("nc_st_addr", dc_if.addr, 32'h60);
    check("nc_st_wdata", dc_if.wdata, 32'h4);
    ack(0);
    check("nc_hit", hit_dc, 1);
    store(32'h20, 32'h20, 1'b0);
    store(32'h24, 32'h24, 1'b0);
    sb_store = 1'b1;
    sb_addr = 32'h28;
    sb_wdata = 32'h28;
    sb_type = 1'b0;
    dc_if.ack = 1'b1;
    tick();
    sb_store = 1'b0;
    dc_if.ack = 1'b0;
    check("fp_hit", hit_dc, 1);
    check("fp_no_err", err_ovf, 0);
    tick();
    check("fp_2nd_addr", dc_if.addr, 32'h24);
    ack(0);
    tick();
    check("fp_3rd_addr", dc_if.addr, 32'h28);
    check("fp_3rd_wdata", dc_if.wdata, 32'h28);
    ack(0);
    check("fp_err_clear", err_ovf, 0);
    store(32'h10, 32'hA1, 1'b0);
    store(32'h14, 32'hA2, 1'b0);
    store(32'h18, 32'hA3, 1'b0);
    check("ov_err", err_ovf, 1);
    check("ov_1st_addr", dc_if.addr, 32'h10);
    ack(0);
    check("ov_hit1", hit_dc, 1);
    tick();
    check("ov_2nd_addr", dc_if.addr, 32'h14);
    check("ov_2nd_wdata", dc_if.wdata, 32'hA2);
    ack(0);
    check("ov_hit2", hit_dc, 1);
    tick();
    tick();
    check("ov_dropped", dc_if.req, 0);
    check("ov_sticky", err_ovf, 1);
    load(32'h30);
    tick();
    check("rl_req", dc_if.req, 1);
    check("rl_we", dc_if.we, 0);
    check("rl_stall", stall, 1);
    reset = 1'b1;
    #1;
    check("rl_req_async", dc_if.req, 0);
    check("rl_stall_async", stall, 0);
    check("rl_err_async", err_ovf, 0);
    check("rl_addr_async", dc_if.addr, 0);
    tick();
    reset = 1'b0;
    ack(32'h99);
    check("rl_no_ldv", ld_valid, 0);
    check("rl_no_hit", hit_dc, 0);
    check("rl_no_req", dc_if.req, 0);
    tick();
    check("rl_no_ldv2", ld_valid, 0);
    check("rl_no_hit2", hit_dc, 0);
    check("rl_ldd", ld_data, 0);
    store(32'h200, 32'h12345678, 1'b0);
    tick();
    check("rs_req", dc_if.req, 1);
    check("rs_addr", dc_if.addr, 32'h200);
    check("rs_wdata", dc_if.wdata, 32'h12345678);
    ack(0);
    check("rs_hit", hit_dc, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
